// File: rtl/regfile_writeback_ctrl_if.sv
// Request/response bundle between the pipeline and the register-file writeback controller.
// The controller sits on the slave modport. The pipeline/driver side uses master.
interface regfile_writeback_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            alu_we;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_wd;

    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_wd;

    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic            WE3;

    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            hazard;
    logic [CW-1:0]   buf_count;

    modport master (
        output alu_we, alu_rd, alu_wd,
        output ld_valid, ld_rd, ld_wd,
        output chk_rs1, chk_rs2,
        input  ld_ready, A3, WD3, WE3, hazard, buf_count
    );

    modport slave (
        input  alu_we, alu_rd, alu_wd,
        input  ld_valid, ld_rd, ld_wd,
        input  chk_rs1, chk_rs2,
        output ld_ready, A3, WD3, WE3, hazard, buf_count
    );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Merges ALU results and buffered load returns into one registered register-file write port,
// with WAW squash of buffered loads and a RAW hazard flag for decode.
module regfile_writeback_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    regfile_writeback_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            kill;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            we3_q, we3_d;

    logic   alu_req;
    logic   ld_ready;
    logic   push;
    logic   pop;
    entry_t head;

    assign alu_req  = bus.alu_we && (bus.alu_rd != '0);
    assign ld_ready = (count_q < CW'(DEPTH));
    // x0 loads complete the handshake but never occupy a slot.
    assign push     = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
    assign pop      = !alu_req && (count_q != '0);
    assign head     = buf_q[rd_ptr_q];

    always_comb begin
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        we3_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (alu_req) begin
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_wd;
            we3_d = 1'b1;
        end else if (pop) begin
            a3_d  = head.rd;
            wd3_d = head.data;
            we3_d = !head.kill;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a3_q     <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;

            // A newer ALU write to the same register makes the older buffered load dead.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_req && vld_q[i] && (buf_q[i].rd == bus.alu_rd)) begin
                    buf_q[i].kill <= 1'b1;
                end
            end

            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
            end

            // The push slot is never valid (not full), so it cannot clash with the kill loop.
            if (push) begin
                buf_q[wr_ptr_q].rd   <= bus.ld_rd;
                buf_q[wr_ptr_q].data <= bus.ld_wd;
                buf_q[wr_ptr_q].kill <= alu_req && (bus.ld_rd == bus.alu_rd);
                vld_q[wr_ptr_q]      <= 1'b1;
            end
        end
    end

    logic hit1, hit2;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !buf_q[i].kill) begin
                if (buf_q[i].rd == bus.chk_rs1) hit1 = 1'b1;
                if (buf_q[i].rd == bus.chk_rs2) hit2 = 1'b1;
            end
        end
        // The registered write commits at the next edge, so it is still pending for decode.
        if (we3_q && (a3_q == bus.chk_rs1)) hit1 = 1'b1;
        if (we3_q && (a3_q == bus.chk_rs2)) hit2 = 1'b1;
    end

    assign bus.hazard    = ((bus.chk_rs1 != '0) && hit1) || ((bus.chk_rs2 != '0) && hit2);
    assign bus.ld_ready  = ld_ready;
    assign bus.buf_count = count_q;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.WE3       = we3_q;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-based model.
module tb_regfile_writeback_ctrl;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_ctrl_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();

    regfile_writeback_ctrl #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue of pending loads and the expected write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    ent_t        m_q[$];
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_rf [32];
    logic [31:0] rf_dut [32];
    bit          armed = 0;

    always @(posedge clk) begin
        bit   areq;
        bit   hs;
        ent_t e;
        if (m_we && armed) m_rf[m_a3] = m_wd;
        if (rst) begin
            m_q.delete();
            m_we  = 0;
            m_a3  = 0;
            m_wd  = 0;
            armed = 1;
        end else if (armed) begin
            hs   = bus.ld_valid && (m_q.size() < DEPTH);
            areq = bus.alu_we && (bus.alu_rd != 0);
            if (areq) begin
                foreach (m_q[i]) if (m_q[i].rd == bus.alu_rd) m_q[i].kill = 1;
                m_we = 1;
                m_a3 = bus.alu_rd;
                m_wd = bus.alu_wd;
            end else if (m_q.size() > 0) begin
                e    = m_q.pop_front();
                m_we = !e.kill;
                m_a3 = e.rd;
                m_wd = e.data;
            end else begin
                m_we = 0;
            end
            if (hs && bus.ld_rd != 0) begin
                e.rd   = bus.ld_rd;
                e.data = bus.ld_wd;
                e.kill = areq && (bus.ld_rd == bus.alu_rd);
                m_q.push_back(e);
            end
        end
    end

    // Register file as actually written by the DUT port.
    always @(posedge clk) begin
        if (bus.WE3 === 1'b1) rf_dut[bus.A3] <= bus.WD3;
    end

    function automatic bit model_haz(input logic [4:0] s);
        if (s == 0) return 0;
        if (m_we && m_a3 == s) return 1;
        foreach (m_q[i]) if (!m_q[i].kill && m_q[i].rd == s) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            check("we3", {31'b0, bus.WE3}, {31'b0, m_we});
            check("a3", {27'b0, bus.A3}, {27'b0, m_a3});
            check("wd3", bus.WD3, m_wd);
            check("ld_ready", {31'b0, bus.ld_ready}, {31'b0, m_q.size() < DEPTH});
            check("buf_count", {29'b0, bus.buf_count}, m_q.size());
            check("hazard", {31'b0, bus.hazard},
                  {31'b0, model_haz(bus.chk_rs1) || model_haz(bus.chk_rs2)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_we   = 0;
        bus.alu_rd   = 0;
        bus.alu_wd   = 0;
        bus.ld_valid = 0;
        bus.ld_rd    = 0;
        bus.ld_wd    = 0;
        bus.chk_rs1  = 0;
        bus.chk_rs2  = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] wd);
        bus.alu_we = 1;
        bus.alu_rd = rd;
        bus.alu_wd = wd;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] wd);
        bus.ld_valid = 1;
        bus.ld_rd    = rd;
        bus.ld_wd    = wd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 0;
            rf_dut[i] = 0;
        end
        idle();
        rst = 1;
        tick();
        rst = 0;
        check("rst_we3", {31'b0, bus.WE3}, 0);
        check("rst_a3", {27'b0, bus.A3}, 0);
        check("rst_wd3", bus.WD3, 0);
        check("rst_count", {29'b0, bus.buf_count}, 0);
        check("rst_ready", {31'b0, bus.ld_ready}, 1);

        // Single ALU write.
        alu(5, 32'hDEADBEEF);
        tick();
        idle();
        check("alu_we3", {31'b0, bus.WE3}, 1);
        check("alu_a3", {27'b0, bus.A3}, 5);
        check("alu_wd3", bus.WD3, 32'hDEADBEEF);
        tick();
        check("alu_we3_off", {31'b0, bus.WE3}, 0);

        // Single load through the buffer.
        ld(7, 32'h12345678);
        check("ld_ready1", {31'b0, bus.ld_ready}, 1);
        tick();
        idle();
        check("ld_count1", {29'b0, bus.buf_count}, 1);
        check("ld_we3_early", {31'b0, bus.WE3}, 0);
        tick();
        check("ld_we3", {31'b0, bus.WE3}, 1);
        check("ld_a3", {27'b0, bus.A3}, 7);
        check("ld_wd3", bus.WD3, 32'h12345678);
        check("ld_count0", {29'b0, bus.buf_count}, 0);

        // Fill under continuous ALU traffic, then drain with wrap-around.
        alu(1, 32'hA);
        for (int i = 0; i < 5; i++) begin
            ld(5'(10 + i), 32'h100 + i);
            if (i == 4) begin
                check("full_ready", {31'b0, bus.ld_ready}, 0);
                check("full_count", {29'b0, bus.buf_count}, 4);
                check("model_full", m_q.size(), 4);
            end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_we3", {31'b0, bus.WE3}, 1);
            check("drain_a3", {27'b0, bus.A3}, 10 + i);
            check("drain_wd3", bus.WD3, 32'h100 + i);
            if (i == 0) check("drain_ready", {31'b0, bus.ld_ready}, 1);
        end

        // WAW squash of a buffered load.
        alu(1, 32'hB);
        ld(9, 32'h1);
        tick();
        idle();
        alu(9, 32'h2);
        tick();
        idle();
        check("waw_alu_a3", {27'b0, bus.A3}, 9);
        check("waw_alu_wd3", bus.WD3, 32'h2);
        tick();
        check("waw_kill_we3", {31'b0, bus.WE3}, 0);
        tick();
        check("waw_rf9", rf_dut[9], 32'h2);
        check("waw_model_rf9", m_rf[9], 32'h2);

        // RAW hazard, x0 handling.
        alu(1, 32'h0);
        ld(3, 32'h33);
        tick();
        idle();
        alu(1, 32'h0);
        bus.chk_rs1 = 3;
        #1;
        check("haz_pending", {31'b0, bus.hazard}, 1);
        idle();
        tick();
        tick();
        alu(0, 32'hFFFF);
        #1;
        check("haz_x0", {31'b0, bus.hazard}, 0);
        tick();
        check("x0_we3", {31'b0, bus.WE3}, 0);
        idle();
        ld(0, 32'h55);
        tick();
        idle();
        check("x0_ld_count", {29'b0, bus.buf_count}, 0);
        tick();

        // Reset mid-drain.
        alu(2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            ld(5'(20 + i), 32'h200 + i);
            tick();
        end
        idle();
        tick();
        check("mid_a3", {27'b0, bus.A3}, 20);
        check("mid_count", {29'b0, bus.buf_count}, 2);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_we3", {31'b0, bus.WE3}, 0);
        check("mid_rst_count", {29'b0, bus.buf_count}, 0);
        check("mid_rst_ready", {31'b0, bus.ld_ready}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_we3", {31'b0, bus.WE3}, 0);
        end

        // Randomized traffic with phases of increasing ALU pressure.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 500; c++) begin
                int unsigned alu_pct;
                alu_pct      = (p == 0) ? 20 : (p == 1) ? 50 : (p == 2) ? 80 : 95;
                rst          = ($urandom_range(0, 99) == 0);
                bus.alu_we   = ($urandom_range(0, 99) < alu_pct);
                bus.alu_rd   = 5'($urandom_range(0, 7));
                bus.alu_wd   = $urandom;
                bus.ld_valid = ($urandom_range(0, 99) < 60);
                bus.ld_rd    = 5'($urandom_range(0, 7));
                bus.ld_wd    = $urandom;
                bus.chk_rs1  = 5'($urandom_range(0, 7));
                bus.chk_rs2  = 5'($urandom_range(0, 7));
                tick();
            end
        end
        rst = 0;
        idle();
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
- Write-side initiator for the 32x32 register file: merges single-cycle ALU results and decoupled load-return data into one registered write port (A3/WD3/WE3).
- Buffers load returns in a small in-order FIFO with valid/ready backpressure.
- Squashes stale buffered load writes (WAW).
- Gives the decode stage a RAW hazard flag for pending writes.

Parameters:
- XLEN, 32, data width of register-file writes.
- AW, 5, register address width.
- DEPTH, 4, load-buffer entries. Power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- alu_we  in  1  ALU write request. Always accepted; no backpressure.
- alu_rd  in  AW  ALU destination register.
- alu_wd  in  XLEN  ALU write data.
- ld_valid  in  1  load-return data valid.
- ld_ready  out  1  load buffer can accept.
- ld_rd  in  AW  load destination register.
- ld_wd  in  XLEN  load data.
- A3  out  AW  register-file write address (registered).
- WD3  out  XLEN  register-file write data (registered).
- WE3  out  1  register-file write enable (registered).
- chk_rs1  in  AW  decode source 1 to check.
- chk_rs2  in  AW  decode source 2 to check.
- hazard  out  1  a source has a pending write (combinational).
- buf_count  out  $clog2(DEPTH)+1  occupied buffer entries.

Behaviour:
- Reset (rst=1 at posedge):
  - WE3=0, A3=0, WD3=0.
  - Buffer emptied: all entries invalid, read/write pointers 0, buf_count=0.
  - ld_ready=1 in the cycle after reset.
  - Reset mid-operation discards buffered loads with no write issued.
- Buffer entry: {rd, data, kill}. Organised as circular FIFO with wrapping pointers plus a count register.
- Enqueue: ld_valid && ld_ready at posedge.
  - ld_rd=0: handshake completes, nothing is stored (x0 write discarded).
- ld_ready = (buf_count < DEPTH), computed from the pre-edge count. A pop in the same cycle does not free a slot for a same-cycle push.
- Output stage, updated every posedge in priority order:
  1. alu_we && alu_rd!=0: A3=alu_rd, WD3=alu_wd, WE3=1.
  2. Else, buffer non-empty: pop head. A3=head.rd, WD3=head.data, WE3=!head.kill.
  3. Else: WE3=0. A3 and WD3 hold their previous values.
- alu_we with alu_rd=0 counts as no request, so the buffer may drain that cycle.
- Latency:
  - ALU write reaches WE3 one cycle after request.
  - Load reaches WE3 no earlier than two cycles after handshake; it always passes through the buffer, with no bypass.
- ALU priority is absolute. The buffer may wait indefinitely under continuous ALU writes; ld_ready then deasserts once the buffer is full.
- WAW squash: an ALU write with alu_rd!=0 sets kill on every valid buffer entry whose rd equals alu_rd. This includes an entry enqueued in the same cycle, since the load is treated as older. A killed entry still pops in order but produces WE3=0.
- Simultaneous push and pop on a non-full buffer: both occur; buf_count is unchanged.
- hazard = 1 iff, for chk_rs1!=0 or chk_rs2!=0, that source equals either:
  - rd of any valid, non-killed buffer entry; or
  - A3 while WE3=1 (register file commits at the next edge).
  chk = 0 never raises hazard.
- Pointer wrap: pointers are modulo DEPTH. Full and empty are distinguished only by buf_count.

Test Plan:
- Reset, then alu_we=1, rd=5, wd=0xDEADBEEF for one cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
- Load rd=7, wd=0x12345678 with no ALU traffic -> ld_ready=1, buf_count=1; one cycle later WE3=1, A3=7, WD3=0x12345678, buf_count=0.
- Hold alu_we=1 (rd=1) and push 5 loads (DEPTH=4) -> 4 accepted, ld_ready=0 on the 5th with buf_count=4. Drop alu_we -> 4 writes drain in order on consecutive cycles; ld_ready returns to 1 after the first pop; wrap-around is exercised.
- Buffer load rd=9 (0x1) and hold alu_we; then ALU write rd=9 (0x2) -> ALU write appears; the later buffered pop shows WE3=0, and x9 ends as 0x2.
- Pending load rd=3, chk_rs1=3 -> hazard=1. chk_rs1=0 with ALU rd=0 request -> hazard=0, WE3 stays 0. Load with rd=0 -> accepted, buf_count stays 0.
- Fill buffer with 3 entries, assert rst for one cycle mid-drain -> WE3=0, buf_count=0, ld_ready=1; no stale writes afterwards.
